// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding the UART transmit data-in bus.
// Holds the oldest byte on uart_bits until the UART's accept strobe and
// presents 8'h00 (UART idle code) whenever the queue is empty.
// Bytes whose two low bits are zero are discarded at the push side.
// Optional feature: define UART_TXQ_DROP_CNT_EN to add a saturating
// drop_count port that counts rejected pushes.
module uart_tx_queue #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push_valid,
  input  logic [7:0]    push_bits,
  output logic          push_ready,
  output logic [7:0]    uart_bits,
  input  logic          uart_ready,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
`ifdef UART_TXQ_DROP_CNT_EN
  ,
  output logic [7:0]    drop_count
`endif
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          bits_ok;
  logic          push_ok;
  logic          pop_ok;

  // Status and handshake qualifiers, all derived from registered count
  always_comb begin
    empty      = (count == '0);
    full       = (count == (AW+1)'(DEPTH));
    level      = count;
    push_ready = !full;
    bits_ok    = (push_bits[1:0] != 2'b00);
    push_ok    = push_valid && !full && bits_ok;
    pop_ok     = uart_ready && !empty;
  end

  // Storage array; contents are not reset
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_bits;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head of queue toward the UART, idle code when empty
  always_comb begin
    uart_bits = empty ? 8'h00 : mem[rd_ptr];
  end

`ifdef UART_TXQ_DROP_CNT_EN
  logic reject;

  // A push is rejected when the queue is full or the byte is untransmittable
  always_comb begin
    reject = push_valid && (full || !bits_ok);
  end

  // Saturating count of rejected pushes, cleared only by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (reject && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed self-checking bench for uart_tx_queue (DEPTH = 8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// drop_count checks are compiled only when UART_TXQ_DROP_CNT_EN is defined.
module tb_uart_tx_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          push_valid = 1'b0;
  logic [7:0]    push_bits = 8'h00;
  logic          push_ready;
  logic [7:0]    uart_bits;
  logic          uart_ready = 1'b0;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] q [$];

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_valid (push_valid),
    .push_bits  (push_bits),
    .push_ready (push_ready),
    .uart_bits  (uart_bits),
    .uart_ready (uart_ready),
    .level      (level),
    .empty      (empty),
    .full       (full)
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    push_valid = 1'b0;
    uart_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] b);
    push_valid = 1'b1;
    push_bits  = b;
    step();
  endtask

  task automatic pop();
    uart_ready = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    q.delete();
  endtask

  function automatic logic [7:0] val(input int i, input logic [1:0] lo);
    logic [5:0] hi;
    hi = 6'(i + 1);
    return {hi, lo};
  endfunction

  initial begin
    #7;
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_uart_bits", 32'(uart_bits), 32'h00);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
`ifdef UART_TXQ_DROP_CNT_EN
    check("rst_drop", 32'(drop_count), 32'd0);
`endif
    reset_n = 1'b1;
    step();

    // Idle ready pulses on an empty queue
    for (int i = 0; i < 4; i++) begin
      idle(15);
      pop();
      check("idle_bits", 32'(uart_bits), 32'h00);
      check("idle_level", 32'(level), 32'd0);
    end

    // Three back-to-back pushes, one pop per 176 cycles
    push(8'h05);
    check("lat_bits", 32'(uart_bits), 32'h05);
    check("lat_level", 32'(level), 32'd1);
    push(8'h06);
    push(8'h07);
    check("three_level", 32'(level), 32'd3);
    begin
      logic [7:0] nxt [3];
      logic [7:0] cur;
      nxt[0] = 8'h06; nxt[1] = 8'h07; nxt[2] = 8'h00;
      cur = 8'h05;
      for (int i = 0; i < 3; i++) begin
        idle(175);
        check("hold_bits", 32'(uart_bits), 32'(cur));
        pop();
        check("adv_bits", 32'(uart_bits), 32'(nxt[i]));
        check("adv_level", 32'(level), 32'(2 - i));
        cur = nxt[i];
      end
    end
    check("after_drain_empty", 32'(empty), 32'd1);

    // Fill past DEPTH, then drain in order
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(val(i, 2'b01));
      if (i < DEPTH) q.push_back(val(i, 2'b01));
      if (i == DEPTH - 1) begin
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(push_ready), 32'd0);
      end
    end
    check("fill_level", 32'(level), 32'd8);
    check("fill_head", 32'(uart_bits), 32'h05);
`ifdef UART_TXQ_DROP_CNT_EN
    check("fill_drop", 32'(drop_count), 32'd2);
`endif
    // Push while full with a pop: push rejected, pop proceeds
    push_valid = 1'b1;
    push_bits  = 8'hFD;
    uart_ready = 1'b1;
    step();
    void'(q.pop_front());
    check("fullpp_level", 32'(level), 32'd7);
    check("fullpp_full", 32'(full), 32'd0);
`ifdef UART_TXQ_DROP_CNT_EN
    check("fullpp_drop", 32'(drop_count), 32'd3);
`endif
    while (q.size() > 0) begin
      check("drain_bits", 32'(uart_bits), 32'(q[0]));
      pop();
      void'(q.pop_front());
    end
    check("drain_end_bits", 32'(uart_bits), 32'h00);
    check("drain_end_level", 32'(level), 32'd0);

    // Zero-low-bits push is discarded
    do_reset();
    push_valid = 1'b1;
    push_bits  = 8'h04;
    #1;
    check("zero_ready", 32'(push_ready), 32'd1);
    step();
    check("zero_level", 32'(level), 32'd0);
    check("zero_bits", 32'(uart_bits), 32'h00);
`ifdef UART_TXQ_DROP_CNT_EN
    check("zero_drop", 32'(drop_count), 32'd1);
`endif

    // Push into empty queue with uart_ready: stored, no pop
    do_reset();
    push_valid = 1'b1;
    push_bits  = 8'h0B;
    uart_ready = 1'b1;
    step();
    check("emptypp_level", 32'(level), 32'd1);
    check("emptypp_bits", 32'(uart_bits), 32'h0B);

    // Simultaneous push/pop at level 3 across pointer wrap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(val(i, 2'b11));
      q.push_back(val(i, 2'b11));
    end
    for (int i = 3; i < 23; i++) begin
      check("wrap_head", 32'(uart_bits), 32'(q[0]));
      push_valid = 1'b1;
      push_bits  = val(i, 2'b10);
      uart_ready = 1'b1;
      step();
      void'(q.pop_front());
      q.push_back(val(i, 2'b10));
      check("wrap_level", 32'(level), 32'd3);
    end
    while (q.size() > 0) begin
      check("wrap_drain", 32'(uart_bits), 32'(q[0]));
      pop();
      void'(q.pop_front());
    end
    check("wrap_empty", 32'(empty), 32'd1);

    // Asynchronous reset with 5 bytes queued and uart_ready high
    do_reset();
    for (int i = 0; i < 5; i++) push(val(i, 2'b01));
    push(8'h00);
    check("pre_arst_level", 32'(level), 32'd5);
    uart_ready = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_bits", 32'(uart_bits), 32'h00);
    check("arst_empty", 32'(empty), 32'd1);
`ifdef UART_TXQ_DROP_CNT_EN
    check("arst_drop", 32'(drop_count), 32'd0);
`endif
    #2;
    reset_n = 1'b1;
    uart_ready = 1'b0;
    push(8'h09);
    check("post_arst_bits", 32'(uart_bits), 32'h09);
    check("post_arst_level", 32'(level), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

- Byte queue that sits directly upstream of the UART transmit path.
- Game/control logic pushes command bytes. The block holds the oldest byte stable on the UART data-in bus until the UART pulses its accept strobe, then advances to the next byte.
- Presents 8'h00 (the UART's idle code) whenever empty, so the UART never launches a frame from stale data.
- Runs in the UART clock domain (16 × baud).

## Interface

Parameters:
- DEPTH, 8, number of queued bytes; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clock  in  1  UART clock, 16 × baud; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- push_valid  in  1  producer offers push_bits this cycle
- push_bits  in  8  command byte; bits[1:0] must be non-zero to be transmittable
- push_ready  out  1  = !full
- uart_bits  out  8  byte to UART data-in; head of queue when non-empty, else 8'h00
- uart_ready  in  1  one-cycle pulse from the UART, high on every bit tick while the UART is idle
- level  out  AW+1  number of stored bytes, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- drop_count  out  8  present only with UART_TXQ_DROP_CNT_EN; see Configuration

## Operation

- Storage: DEPTH × 8 register array, write pointer wr_ptr[AW-1:0], read pointer rd_ptr[AW-1:0], count[AW:0]. Pointers wrap modulo DEPTH naturally.
- Accepted push requires push_valid & !full & (push_bits[1:0] != 2'b00):
  - Write mem[wr_ptr], increment wr_ptr and count.
- Rejected push:
  - Condition: push_valid & full, or push_valid & push_bits[1:0] == 2'b00.
  - No state change except the drop counter when enabled.
  - A zero-low-bits push still sees push_ready = 1 but is discarded, because the UART treats such a byte as idle and would never send it.
- Pop requires uart_ready & !empty:
  - Increment rd_ptr, decrement count.
  - uart_ready while empty is ignored; the UART pulses ready every idle tick, and in that state it sees 8'h00 and does not start a frame.
- Output: uart_bits = empty ? 8'h00 : mem[rd_ptr]. Combinational from registered state only; no combinational path from push_* or uart_ready.
- Simultaneous push and pop with 0 < count < DEPTH: both happen and count is unchanged.
- Push into an empty queue in the same cycle as uart_ready: the push is stored and no pop occurs, because empty is evaluated on registered count.
- Push while full in the same cycle as a pop: the push is rejected (push_ready is already 0); the pop proceeds.
- Asynchronous reset mid-transmission:
  - Pointers, count and drop_count clear.
  - Array contents need not clear.
  - uart_bits goes to 8'h00 immediately.
  - A byte already latched by the UART is unaffected.

## Timing

- Reset values: push_ready = 1, uart_bits = 8'h00, level = 0, empty = 1, full = 0, drop_count = 0.
- Latency from push to uart_bits: 1 cycle (byte visible the cycle after the accepting edge when the queue was empty).
- Advance after pop: the next head (or 8'h00) is visible the cycle after the uart_ready pulse.
- Holding rule: uart_bits is stable from the cycle it first shows a byte until the cycle after the uart_ready pulse that consumes it.
- Throughput: one byte per UART frame (about 11 bit-ticks). The queue imposes no extra gap.
- full asserts the cycle after the DEPTH-th accepted push. push_ready deasserts on the same edge.

## Configuration

- UART_TXQ_DROP_CNT_EN defined:
  - drop_count[7:0] port exists.
  - Increments by 1 on every rejected push (full or zero low bits) and saturates at 8'hFF.
  - Cleared only by reset_n.
- UART_TXQ_DROP_CNT_EN undefined:
  - Port and counter are absent.
  - Rejected pushes are dropped silently.
  - All other behaviour is identical.

## Test plan

- Reset, no pushes, uart_ready pulsed every 16 cycles: uart_bits holds 8'h00, level = 0, no pointer movement.
- Push 8'h05, 8'h06, 8'h07 back-to-back, uart_ready pulsed once per 176 cycles: uart_bits shows 8'h05, then 8'h06, then 8'h07, then 8'h00, each change one cycle after a pulse; level steps 3→2→1→0.
- DEPTH = 8, push 10 valid bytes with no pops: level = 8, full = 1 after the 8th push, pushes 9–10 are rejected, drop_count = 2; draining then returns bytes 1–8 in order.
- Push 8'h04 (low bits 00): level stays 0, uart_bits stays 8'h00, drop_count = 1.
- Pre-fill 3 bytes, then in one cycle push and pulse uart_ready: level stays 3 and order is preserved across pointer wrap (run 20 bytes through DEPTH = 8).
- Assert reset_n low with 5 bytes queued while uart_ready is high: level = 0, uart_bits = 8'h00, drop_count = 0 asynchronously; the next push after release appears as the head.
